// File: rtl/dct_pkg.sv
// Shared constants and lane helpers for the row-DCT front end and butterfly stages.
package dct_pkg;

  localparam int DCT_DW = 8;
  localparam int DCT_N  = 8;
  localparam int HALF   = DCT_N / 2;

  // LSB position of a lane inside a packed half-row bus.
  function automatic int lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/dct_eo_split_if.sv
// Serial sample input and parallel even/odd half-row output handshake bundle.
interface dct_eo_split_if
  import dct_pkg::*;
#(
  parameter int DW = DCT_DW,
  parameter int N  = DCT_N
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [N/2*DW-1:0]     out_even;
  logic [N/2*DW-1:0]     out_odd;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_even, out_odd
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_even, out_odd
  );

endinterface

// File: rtl/dct_row_bank.sv
// One row of N samples; even/odd lanes are pure wiring off the storage.
module dct_row_bank
  import dct_pkg::*;
#(
  parameter int DW = DCT_DW,
  parameter int N  = DCT_N,
  localparam int IW = $clog2(N)
) (
  input  logic                clk,
  input  logic                clr_i,
  input  logic                we_i,
  input  logic [IW-1:0]       idx_i,
  input  logic [DW-1:0]       data_i,
  output logic [N/2*DW-1:0]   even_o,
  output logic [N/2*DW-1:0]   odd_o
);

  logic [DW-1:0] mem_q [N];

  // Sample storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[idx_i] <= data_i;
    end
  end

  for (genvar j = 0; j < N / 2; j++) begin : g_lane
    assign even_o[lane_lsb(j, DW) +: DW] = mem_q[2*j];
    assign odd_o[lane_lsb(j, DW) +: DW]  = mem_q[2*j+1];
  end

endmodule

// File: rtl/dct_eo_split.sv
// Ping-pong even/odd row splitter: serial samples in, one split row per handshake out.
module dct_eo_split
  import dct_pkg::*;
#(
  parameter int DW = DCT_DW,
  parameter int N  = DCT_N
) (
  input  logic            clk,
  input  logic            rst,
  dct_eo_split_if.slave   bus,
  output logic            err_frame
);

  localparam int             IW       = $clog2(N);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IW-1:0]     wr_idx_q, wr_idx_d;
  logic              err_q, err_d;
  logic              accept_s, row_end_s, short_s, pop_s;
  logic [N/2*DW-1:0] even_s [2];
  logic [N/2*DW-1:0] odd_s  [2];

  assign bus.in_ready  = !rst && !full_q[wr_bank_q];
  assign bus.out_valid = full_q[rd_bank_q];
  assign bus.out_even  = rd_bank_q ? even_s[1] : even_s[0];
  assign bus.out_odd   = rd_bank_q ? odd_s[1]  : odd_s[0];
  assign err_frame     = err_q;

  // Handshake decode and next-state for pointers, full flags and framing error.
  always_comb begin
    accept_s  = bus.in_valid && bus.in_ready;
    row_end_s = accept_s && (wr_idx_q == LAST_IDX);
    short_s   = accept_s && bus.in_last && (wr_idx_q != LAST_IDX);
    pop_s     = full_q[rd_bank_q] && bus.out_ready;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    err_d     = 1'b0;
    // A pop and a completion never target the same bank: a full write bank blocks input.
    if (pop_s) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end
    if (row_end_s) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
      wr_idx_d          = '0;
      err_d             = !bus.in_last;
    end else if (short_s) begin
      wr_idx_d = '0;
      err_d    = 1'b1;
    end else if (accept_s) begin
      wr_idx_d = wr_idx_q + 1'b1;
    end else begin
      wr_idx_d = wr_idx_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      err_q     <= err_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_row_bank #(.DW(DW), .N(N)) u_bank (
      .clk    (clk),
      .clr_i  (rst),
      .we_i   (accept_s && (wr_bank_q == 1'(b))),
      .idx_i  (wr_idx_q),
      .data_i (bus.in_data),
      .even_o (even_s[b]),
      .odd_o  (odd_s[b])
    );
  end

endmodule

// File: tb/tb_dct_eo_split.sv
// Randomized scoreboard bench for dct_eo_split against a row-level reference model.
module tb_dct_eo_split;
  import dct_pkg::*;

  localparam int DW = DCT_DW;
  localparam int N  = DCT_N;
  localparam int H  = HALF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_frame;

  dct_eo_split_if #(.DW(DW), .N(N)) bus ();

  dct_eo_split #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: queue of expected {even, odd} rows plus row assembly.
  logic [2*H*DW-1:0] exp_q [$];
  logic [DW-1:0]     m_row [N];
  int                m_idx = 0;
  bit                err_pend = 1'b0;
  int                acc_cnt = 0;
  int                err_cnt = 0;
  bit                rnd_en = 1'b0;
  logic [DW-1:0]     row_buf [N];

  logic              m_rdy;
  logic [H*DW-1:0]   m_ev, m_od;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the model, then advance the model by one edge.
  always @(negedge clk) begin
    if (rst) begin
      check("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
      exp_q.delete();
      m_idx    = 0;
      err_pend = 1'b0;
    end else begin
      m_rdy = (exp_q.size() < 2);
      check("in_ready", 64'(bus.in_ready), 64'(m_rdy));
      check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
      check("err_frame", 64'(err_frame), 64'(err_pend));
      if (err_frame) err_cnt++;
      err_pend = 1'b0;
      if (exp_q.size() > 0) begin
        check("out_even", 64'(bus.out_even), 64'(exp_q[0][2*H*DW-1:H*DW]));
        check("out_odd",  64'(bus.out_odd),  64'(exp_q[0][H*DW-1:0]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
      if (bus.in_valid && m_rdy) begin
        acc_cnt++;
        m_row[m_idx] = bus.in_data;
        if (m_idx == N - 1) begin
          for (int j = 0; j < H; j++) begin
            m_ev[j*DW +: DW] = m_row[2*j];
            m_od[j*DW +: DW] = m_row[2*j+1];
          end
          exp_q.push_back({m_ev, m_od});
          err_pend = !bus.in_last;
          m_idx    = 0;
        end else if (bus.in_last) begin
          err_pend = 1'b1;
          m_idx    = 0;
        end else begin
          m_idx++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_en) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("send_timeout", 64'd1, 64'd0);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_row(input int len, input bit drop_last);
    for (int i = 0; i < len; i++) begin
      send(row_buf[i], (i == len - 1) && !drop_last);
    end
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) row_buf[i] = base + DW'(i);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    @(negedge clk);
    check("drain_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, e0, len;
    bit drop;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;

    // 1: reset for two edges
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_err", 64'(err_frame), 64'd0);
    check("rst_even", 64'(bus.out_even), 64'd0);
    check("rst_odd", 64'(bus.out_odd), 64'd0);
    tick();

    // 2: single row
    bus.out_ready = 1'b1;
    fill(8'h10);
    send_row(N, 1'b0);
    @(negedge clk);
    check("row_valid_lat1", 64'(bus.out_valid), 64'd1);
    check("row_even", 64'(bus.out_even), 64'h16141210);
    check("row_odd", 64'(bus.out_odd), 64'h17151311);
    tick();
    drain();

    // 3: backpressure with three rows offered
    bus.out_ready = 1'b0;
    a0 = acc_cnt;
    fill(8'h30); send_row(N, 1'b0);
    fill(8'h40); send_row(N, 1'b0);
    fill(8'h50);
    bus.in_valid = 1'b1;
    bus.in_data  = row_buf[0];
    repeat (4) tick();
    @(negedge clk);
    check("bp_accepted", 64'(acc_cnt - a0), 64'd16);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_hold_even", 64'(bus.out_even), 64'h36343230);
    tick();
    bus.out_ready = 1'b1;
    send_row(N, 1'b0);
    drain();
    check("bp_total", 64'(acc_cnt - a0), 64'd24);

    // 4: short row then full row
    e0 = err_cnt;
    fill(8'h60);
    send_row(5, 1'b0);
    tick(); tick();
    @(negedge clk);
    check("short_err_count", 64'(err_cnt - e0), 64'd1);
    check("short_no_valid", 64'(bus.out_valid), 64'd0);
    tick();
    fill(8'h20);
    send_row(N, 1'b0);
    @(negedge clk);
    check("after_short_even", 64'(bus.out_even), 64'h26242220);
    check("after_short_odd", 64'(bus.out_odd), 64'h27252321);
    tick();
    drain();

    // 5: pop on the same edge as next row completion
    bus.out_ready = 1'b0;
    fill(8'h70); send_row(N, 1'b0);
    fill(8'h80);
    for (int i = 0; i < N - 1; i++) send(row_buf[i], 1'b0);
    bus.out_ready = 1'b1;
    send(row_buf[N-1], 1'b1);
    @(negedge clk);
    check("simul_valid", 64'(bus.out_valid), 64'd1);
    check("simul_even", 64'(bus.out_even), 64'h86848280);
    check("simul_odd", 64'(bus.out_odd), 64'h87858381);
    tick();
    drain();

    // 6: mid-row reset
    e0 = err_cnt;
    fill(8'h90);
    for (int i = 0; i < 4; i++) send(row_buf[i], 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_err", 64'(err_frame), 64'd0);
    tick();
    fill(8'hA0);
    send_row(N, 1'b0);
    @(negedge clk);
    check("midrst_even", 64'(bus.out_even), 64'hA6A4A2A0);
    tick();
    drain();
    check("midrst_err_count", 64'(err_cnt - e0), 64'd0);

    // Random rows with random backpressure and framing faults
    rnd_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      len  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, N - 1)) : N;
      drop = (len == N) && ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) row_buf[i] = DW'($urandom);
      send_row(len, drop);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd_en = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
